// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequence generator.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_t;

    localparam int SEED0_DEFAULT = 5;
    localparam int SEED1_DEFAULT = 7;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/fib_sum.sv
// Combinational WIDTH+1 adder producing the next term, with wrap or saturate on overflow.
module fib_sum
    import fib_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign carry    = full_sum[WIDTH];
    assign sum      = (carry && (sat_mode == MODE_SAT)) ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];

endmodule

// File: rtl/fib_seq_gen.sv
// Parametrised Fibonacci-style sequence generator: emits n_terms terms from
// programmable or default seeds over a valid/ready stream, with start/busy/done control.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH     = 17,
    parameter int CNT_W     = 5,
    parameter int SEED0_DEF = SEED0_DEFAULT,
    parameter int SEED1_DEF = SEED1_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic             use_seeds,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] term,
    output logic [CNT_W-1:0] term_idx,
    output logic             term_valid,
    input  logic             term_ready,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] SEED0_W = WIDTH'(SEED0_DEF);
    localparam logic [WIDTH-1:0] SEED1_W = WIDTH'(SEED1_DEF);

    fib_state_t state, state_next;

    logic [WIDTH-1:0] a_q, b_q, term_q;
    logic [CNT_W-1:0] idx_q, n_q;
    logic             sat_q, ovf_q;

    logic [WIDTH-1:0] next_sum;
    logic             sum_carry;
    logic             start_ok, handshake, last_term;
    logic [WIDTH-1:0] first_seed, second_seed;

    fib_sum #(.WIDTH(WIDTH)) u_sum (
        .a        (a_q),
        .b        (b_q),
        .sat_mode (sat_q),
        .sum      (next_sum),
        .carry    (sum_carry)
    );

    assign start_ok    = (state == IDLE) && start;
    assign handshake   = (state == RUN) && term_ready;
    assign last_term   = (idx_q == (n_q - CNT_W'(1)));
    assign first_seed  = use_seeds ? seed0 : SEED0_W;
    assign second_seed = use_seeds ? seed1 : SEED1_W;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (n_terms != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (handshake && last_term) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // term mirrors a but keeps its own register so it reads 0 out of reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q    <= SEED0_W;
            b_q    <= SEED1_W;
            term_q <= '0;
            idx_q  <= '0;
            n_q    <= '0;
            sat_q  <= MODE_WRAP;
            ovf_q  <= 1'b0;
        end else if (start_ok) begin
            a_q    <= first_seed;
            b_q    <= second_seed;
            term_q <= first_seed;
            idx_q  <= '0;
            n_q    <= n_terms;
            sat_q  <= sat_mode;
            ovf_q  <= 1'b0;
        end else if (handshake) begin
            a_q    <= b_q;
            b_q    <= next_sum;
            term_q <= b_q;
            idx_q  <= idx_q + CNT_W'(1);
            ovf_q  <= ovf_q | sum_carry;
        end
    end

    assign term       = term_q;
    assign term_idx   = idx_q;
    assign term_valid = (state == RUN);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign ovf        = ovf_q;

endmodule
